// File: rtl/count_display_driver.sv
// Captures a ones/zeros count pair, converts each to BCD with a shift-add-3 engine,
// and scans the four digits onto a common-anode 7-segment display (macro: LEADING_ZERO_BLANK_EN).
module count_display_driver (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] count_ones,
   input  logic [5:0] count_zeros,
   input  logic       scan_clk,
   output logic       busy,
   output logic [3:0] an,
   output logic [6:0] seg
);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t          state_q;
   logic            busy_q;
   logic [2:0]      iter_q;
   logic [5:0]      onesBin_q, zerosBin_q;
   logic [7:0]      onesBcd_q, zerosBcd_q;
   logic [3:0][3:0] digits_q;
   logic [13:0]     onesStep_d, zerosStep_d;

   logic            scanPrev_q;
   logic [1:0]      scanIdx_q;
   logic [3:0]      an_q;
   logic [6:0]      seg_q;
   logic [3:0]      curDigit_d;
   logic [6:0]      seg_d;
   logic            scanEdge_d;

   function automatic logic [7:0] add3(input logic [7:0] bcd);
      logic [3:0] tens, units;
      tens  = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
      units = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
      return {tens, units};
   endfunction

   function automatic logic [6:0] segOf(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // One double-dabble iteration: correct the BCD nibbles, then shift {bcd, bin} left.
   always_comb begin
      onesStep_d  = {add3(onesBcd_q), onesBin_q};
      onesStep_d  = {onesStep_d[12:0], 1'b0};
      zerosStep_d = {add3(zerosBcd_q), zerosBin_q};
      zerosStep_d = {zerosStep_d[12:0], 1'b0};
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         iter_q     <= 3'd0;
         onesBin_q  <= 6'd0;
         zerosBin_q <= 6'd0;
         onesBcd_q  <= 8'd0;
         zerosBcd_q <= 8'd0;
         digits_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  onesBin_q  <= count_ones;
                  zerosBin_q <= count_zeros;
                  onesBcd_q  <= 8'd0;
                  zerosBcd_q <= 8'd0;
                  iter_q     <= 3'd0;
                  busy_q     <= 1'b1;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               onesBcd_q  <= onesStep_d[13:6];
               onesBin_q  <= onesStep_d[5:0];
               zerosBcd_q <= zerosStep_d[13:6];
               zerosBin_q <= zerosStep_d[5:0];
               iter_q     <= iter_q + 3'd1;
               if (iter_q == 3'd5) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               digits_q[3] <= onesBcd_q[7:4];
               digits_q[2] <= onesBcd_q[3:0];
               digits_q[1] <= zerosBcd_q[7:4];
               digits_q[0] <= zerosBcd_q[3:0];
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Odd scan indices are the tens positions, the only ones eligible for blanking.
   always_comb begin
      scanEdge_d = scan_clk & ~scanPrev_q;
      curDigit_d = digits_q[scanIdx_q];
      seg_d      = segOf(curDigit_d);
`ifdef LEADING_ZERO_BLANK_EN
      if (scanIdx_q[0] && (curDigit_d == 4'd0)) begin
         seg_d = 7'b1111111;
      end
`endif
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         scanPrev_q <= 1'b0;
         scanIdx_q  <= 2'd0;
         an_q       <= 4'b1111;
         seg_q      <= 7'b1111111;
      end else begin
         scanPrev_q <= scan_clk;
         if (scanEdge_d) begin
            scanIdx_q <= scanIdx_q + 2'd1;
         end
         an_q  <= ~(4'b0001 << scanIdx_q);
         seg_q <= seg_d;
      end
   end

   assign busy = busy_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule
